ac97_cmd_arbiter: RTL

Shares the single AC97 command slot (slot 1 address / slot 2 data) between NREQ independent requesters, such as volume control, record-source select and diagnostic register reads. Sits in the clock_27mhz domain between the requesters and the frame assembler's command_address/command_data/command_valid inputs. Arbitration happens only on the one-cycle ready pulse, so each granted command stays stable across at least one frame-end latch. Grant order is round-robin, and each requester gets per-requester grant and done pulses.

---
 rtl/ac97_cmd_arbiter_if.sv | 25 ++
 rtl/ac97_cmd_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ac97_cmd_arbiter_if.sv
// rtl/ac97_cmd_arbiter_if.sv - requester and frame-assembler bundle for the AC97 command arbiter
interface ac97_cmd_arbiter_if #(
  parameter int NREQ = 4
);
  logic                 ready;
  logic [NREQ-1:0]      req;
  logic [8*NREQ-1:0]    req_addr;
  logic [16*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      done;
  logic [7:0]           command_address;
  logic [15:0]          command_data;
  logic                 command_valid;
  logic                 busy;

  modport master (
    output ready, req, req_addr, req_data,
    input  grant, done, command_address, command_data, command_valid, busy
  );

  modport slave (
    input  ready, req, req_addr, req_data,
    output grant, done, command_address, command_data, command_valid, busy
  );
endinterface

// File: rtl/ac97_cmd_arbiter.sv
// rtl/ac97_cmd_arbiter.sv - round-robin arbiter sharing the AC97 slot 1/2 command between requesters
// Arbitration and retirement only happen on the per-frame ready pulse.
module ac97_cmd_arbiter #(
  parameter int NREQ        = 4,
  parameter int HOLD_FRAMES = 1
) (
  input  logic              clock_27mhz,
  input  logic              reset_b,
  ac97_cmd_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [3:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      cmd_addr_q, cmd_addr_d;
  logic [15:0]     cmd_data_q, cmd_data_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;

  logic [PW:0]     owner_inc;
  logic [PW-1:0]   ptr_after_owner;
  logic [PW-1:0]   arb_ptr;
  logic [PW-1:0]   win;
  logic            win_found;
  logic            load;

  // On retire the scan starts just past the owner, so the owner's own re-request loses.
  always_comb begin
    owner_inc       = {1'b0, owner_q} + (PW+1)'(1);
    ptr_after_owner = (owner_inc == (PW+1)'(NREQ)) ? '0 : owner_inc[PW-1:0];
    arb_ptr         = (state_q == HOLD) ? ptr_after_owner : rr_ptr_q;
  end

  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    idx       = 0;
    idx_p     = '0;
    win       = '0;
    win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(arb_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_p = PW'(idx);
      if (!win_found && bus.req[idx_p]) begin
        win       = idx_p;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    frame_cnt_d = frame_cnt_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    busy_d      = busy_q;
    grant_d     = '0;
    done_d      = '0;
    load        = 1'b0;

    if (bus.ready) begin
      case (state_q)
        IDLE: begin
          if (win_found) load = 1'b1;
        end
        HOLD: begin
          if (frame_cnt_q < 4'(HOLD_FRAMES - 1)) begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end else begin
            done_d[owner_q] = 1'b1;
            rr_ptr_d        = ptr_after_owner;
            if (win_found) begin
              load = 1'b1;
            end else begin
              cmd_valid_d = 1'b0;
              busy_d      = 1'b0;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Back-to-back loads keep command_valid high so the frame assembler sees no gap.
    if (load) begin
      state_d        = HOLD;
      owner_d        = win;
      frame_cnt_d    = 4'd0;
      cmd_addr_d     = bus.req_addr[{win, 3'b000} +: 8];
      cmd_data_d     = bus.req_data[{win, 4'b0000} +: 16];
      cmd_valid_d    = 1'b1;
      busy_d         = 1'b1;
      grant_d[win]   = 1'b1;
    end
  end

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      frame_cnt_q <= 4'd0;
      cmd_addr_q  <= 8'd0;
      cmd_data_q  <= 16'd0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      frame_cnt_q <= frame_cnt_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
    end
  end

  assign bus.grant           = grant_q;
  assign bus.done            = done_q;
  assign bus.command_address = cmd_addr_q;
  assign bus.command_data    = cmd_data_q;
  assign bus.command_valid   = cmd_valid_q;
  assign bus.busy            = busy_q;
endmodule
